// File: rtl/foo_pipe_pkg.sv
// foo_pipe_pkg: shared constants and helpers for the backpressured compute pipeline.
//   STAGE_INC_EVEN / STAGE_INC_ODD : increments applied by even / odd compute stages
//   occ_width(n)                   : counter width able to hold 0..n+1 words
package foo_pipe_pkg;
   localparam int STAGE_INC_EVEN = 1;
   localparam int STAGE_INC_ODD  = 2;
   function automatic int occ_width(input int n);
      return $clog2(n + 2);
   endfunction
endpackage

// File: rtl/foo_stage_fn.sv
// foo_stage_fn: combinational compute stage f_k between two register ranks.
//   x : DATA_W  word from rank k
//   y : DATA_W  f_k(x), +1 on even stages, +2 on odd stages (mod 2^DATA_W)
module foo_stage_fn
   import foo_pipe_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int STAGE_IDX = 0
) (
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y
);
   // Adding 2 never touches bit 0, so the odd stage only increments the upper field.
   logic [DATA_W-2:0] hi;
   assign hi = x[DATA_W-1:1] + (DATA_W-1)'(STAGE_INC_ODD / 2);
   assign y  = (STAGE_IDX % 2 == 0) ? x + DATA_W'(STAGE_INC_EVEN) : {hi, x[0]};
endmodule

// File: rtl/foo_pipeline_bp.sv
// foo_pipeline_bp: NUM_STAGES compute stages between NUM_STAGES+1 register ranks with ready/valid backpressure.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_valid     : producer word and its valid; in_ready accepts it
//   out_data/out_valid   : result word from the last rank; out_ready consumes it
//   occupancy            : number of valid words currently held
module foo_pipeline_bp
   import foo_pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_STAGES = 2,
   parameter int OCC_W      = occ_width(NUM_STAGES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OCC_W-1:0]  occupancy
);
   localparam int L = NUM_STAGES;
   logic [DATA_W-1:0] d  [0:L];
   logic [DATA_W-1:0] fo [0:L-1];
   logic [L:0]        v;
   logic [L:0]        en;
   for (genvar k = 0; k < L; k++) begin : g_stage
      foo_stage_fn #(.DATA_W(DATA_W), .STAGE_IDX(k)) u_fn (.x(d[k]), .y(fo[k]));
   end
   // Unrolled form of en[k] = !v[k] | en[k+1]: rank k may load unless it and every
   // rank after it are full while the consumer stalls. The mask forces ranks below k to 1.
   always_comb begin
      en = '0;
      for (int k = 0; k <= L; k++)
         en[k] = !(&(v | (((L+1)'(1) << k) - (L+1)'(1)))) | out_ready;
   end
   assign in_ready  = en[0];
   assign out_data  = d[L];
   assign out_valid = v[L];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v         <= '0;
         occupancy <= '0;
         for (int k = 0; k <= L; k++) d[k] <= '0;
      end else begin
         if (en[0]) begin
            v[0] <= in_valid;
            if (in_valid) d[0] <= in_data;
         end
         for (int k = 1; k <= L; k++) begin
            if (en[k]) begin
               v[k] <= v[k-1];
               if (v[k-1]) d[k] <= fo[k-1];
            end
         end
         occupancy <= occupancy + OCC_W'(in_valid & in_ready) - OCC_W'(out_valid & out_ready);
      end
   end
endmodule

// File: doc/foo_pipeline_bp.md
Name: foo_pipeline_bp

Overview:
- Parametrised successor of the stitched two-stage valid pipeline. Chains NUM_STAGES combinational compute stages between NUM_STAGES+1 register ranks.
- Adds ready/valid backpressure with bubble collapsing, an asynchronous active-low reset, generic width, and an occupancy counter.
- Sits between a ready/valid producer and consumer in the stitched-pipeline flow.

Parameters:
- DATA_W, 32, data path width in bits; must be at least 2.
- NUM_STAGES, 2, number of compute stages; must be at least 1. Latency is NUM_STAGES+1.
- OCC_W, $clog2(NUM_STAGES+2), width of the occupancy output.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- in_data  in  DATA_W  input word.
- in_valid  in  1  input word is present.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DATA_W  result word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- occupancy  out  OCC_W  number of valid words held in the pipeline.

Behaviour:
- Register ranks: p[0..L] with L=NUM_STAGES. Each rank has a data register d[k] and a valid bit v[k].
- Stage function f_k, all arithmetic mod 2^DATA_W:
  - even k: y+1.
  - odd k: y+2, implemented as {y[DATA_W-1:1]+1, y[0]}.
  - NUM_STAGES=2 gives a total of +3.
- Enables, combinational chain:
  - en[L] = !v[L] | out_ready.
  - en[k] = !v[k] | en[k+1].
  - in_ready = en[0].
- Load rules when en[k] is high:
  - v[0] <= in_valid; v[k] <= v[k-1].
  - d[0] <= in_data if in_valid; d[k] <= f_{k-1}(d[k-1]) if v[k-1].
  - A valid bit of 0 on the incoming side leaves d unchanged and clears v.
- When en[k] is low, rank k holds both d and v.
- out_data = d[L]; out_valid = v[L].
- Latency: NUM_STAGES+1 cycles from accept to out_valid when unstalled. Throughput is 1 word/cycle with out_ready=1.
- Bubbles: an empty rank accepts even while downstream is stalled, so gaps compact. in_ready deasserts only when all L+1 ranks are valid and out_ready=0.
- Simultaneous events:
  - Full pipeline with out_ready=1 gives in_ready=1, and accept and emit occur in the same cycle.
  - in_valid is allowed to be high while in_ready is low; the word is not taken, and the producer holds it.
- occupancy is a registered counter, reset 0:
  - occ <= occ + (in_valid&in_ready) - (out_valid&out_ready).
  - It always equals popcount(v) and never exceeds L+1.
- Reset, asynchronous and effective immediately, including mid-operation:
  - all v=0, all d=0, occupancy=0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1.
  - In-flight words are discarded. No stale word appears after release.
- No combinational path from in_valid to out_valid. A combinational path from out_ready to in_ready is permitted.

Decomposition:
- Shared package foo_pipe_pkg holds:
  - STAGE_INC_EVEN=1 and STAGE_INC_ODD=2.
  - function occ_width(n) returning $clog2(n+2).
- One sub-module: foo_stage_fn, combinational, parameters DATA_W and STAGE_IDX. It implements f_k and is instantiated NUM_STAGES times via generate.
- The top holds the register ranks, the enable chain and the counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 words in flight. Required immediately, without a clock edge: out_valid=0, occupancy=0, in_ready=1, out_data=0. After release with in_valid=0 for 5 cycles, out_valid stays 0.
- Streaming (defaults, out_ready=1): in_data 0,1,2,... one per cycle. out_data 3,4,5,... starts 3 cycles after the first accept; occupancy holds steady at 3.
- Wrap: in_data 32'hFFFF_FFFE -> 32'h0000_0001; in_data 32'hFFFF_FFFF -> 32'h0000_0002.
- Backpressure: out_ready=0 with continuous in_valid. in_ready falls after exactly 3 accepts; occupancy=3; out_data holds the first result. Raising out_ready drains the words in order with no loss or duplication.
- Bubble collapse: send in_data=10, idle 2 cycles, send 20, with out_ready=0 throughout. in_ready stays 1; v[2]=v[1]=1; occupancy=2; out_data=13. Releasing out_ready then yields 13 followed by 23.
- Parametrised (DATA_W=8, NUM_STAGES=3): in_data 8'hFE -> out_data 8'h02 (+1+2+1) after 4 cycles. Full pipeline gives occupancy=4.
